// File: rtl/alu_pkg.sv
// Shared function codes for the alu_n datapath unit.
package alu_pkg;
  typedef logic [2:0] alu_fn_t;

  localparam alu_fn_t ALU_CLR = 3'b000;
  localparam alu_fn_t ALU_BMA = 3'b001;
  localparam alu_fn_t ALU_AMB = 3'b010;
  localparam alu_fn_t ALU_ADD = 3'b011;
  localparam alu_fn_t ALU_XOR = 3'b100;
  localparam alu_fn_t ALU_OR  = 3'b101;
  localparam alu_fn_t ALU_AND = 3'b110;
  localparam alu_fn_t ALU_SET = 3'b111;
endpackage

// File: rtl/alu_adder.sv
// Combinational N-bit adder; with ALU_OVF_EN it also exposes the carry into the MSB.
module alu_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef ALU_OVF_EN
  ,
  output logic         c_msb
`endif
);
  logic [N:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  assign sum  = full[N-1:0];
  assign cout = full[N];
`ifdef ALU_OVF_EN
  // Sum bit of the MSB is x^y^carry_in, so the carry in falls out of it.
  assign c_msb = x[N-1] ^ y[N-1] ^ full[N-1];
`endif
endmodule

// File: rtl/alu_n.sv
// Registered N-bit ALU: select decode, shared adder, one output register stage.
// Optional signed-overflow output ov is built when ALU_OVF_EN is defined.
module alu_n
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s0,
  input  logic         s1,
  input  logic         s2,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] z,
  output logic         co
`ifdef ALU_OVF_EN
  ,
  output logic         ov
`endif
);
  alu_fn_t     sel;
  logic [N-1:0] add_x, add_y, add_sum;
  logic         add_co;
  logic [N-1:0] z_nxt;
  logic         co_nxt;

  assign sel = {s2, s1, s0};

  // One adder serves all three arithmetic codes; only its operands change.
  always_comb begin
    add_x = a;
    add_y = b;
    case (sel)
      ALU_BMA: add_x = ~a;
      ALU_AMB: add_y = ~b;
      default: ;
    endcase
  end

`ifdef ALU_OVF_EN
  logic add_cm;
  logic ov_nxt;
`endif

  alu_adder #(.N(N)) u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (ci),
    .sum  (add_sum),
    .cout (add_co)
`ifdef ALU_OVF_EN
    ,
    .c_msb(add_cm)
`endif
  );

  always_comb begin
    z_nxt  = '0;
    co_nxt = 1'b0;
    case (sel)
      ALU_BMA, ALU_AMB, ALU_ADD: begin
        z_nxt  = add_sum;
        co_nxt = add_co;
      end
      ALU_XOR: z_nxt = a ^ b;
      ALU_OR:  z_nxt = a | b;
      ALU_AND: z_nxt = a & b;
      ALU_SET: z_nxt = '1;
      default: ;
    endcase
  end

`ifdef ALU_OVF_EN
  assign ov_nxt = (sel == ALU_BMA || sel == ALU_AMB || sel == ALU_ADD) ? (add_cm ^ add_co) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) ov <= 1'b0;
    else     ov <= ov_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      z  <= '0;
      co <= 1'b0;
    end else begin
      z  <= z_nxt;
      co <= co_nxt;
    end
  end
endmodule

// File: tb/tb_alu_n.sv
// Self-checking bench for alu_n (N=4): constant vector table, adder sweep and
// random traffic, all checked through an expected-result queue one cycle later.
module tb_alu_n;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, s0, s1, s2, ci;
  logic [N-1:0] a, b, z;
  logic         co;
`ifdef ALU_OVF_EN
  logic         ov;
`endif

  alu_n #(.N(N)) dut (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1), .s2(s2),
    .a(a), .b(b), .ci(ci), .z(z), .co(co)
`ifdef ALU_OVF_EN
    , .ov(ov)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] z;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [3:0] z;
    logic       co;
    logic       ov;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference built from integer arithmetic and signed range checks.
  function automatic exp_t model(input logic r, input logic [2:0] sel,
                                 input logic [3:0] ia, input logic [3:0] ib, input logic c);
    exp_t e;
    int   ux, uy, sx, sy, t, st;
    logic [3:0] fx, fy;
    e.z = 4'h0; e.co = 1'b0; e.ov = 1'b0; e.tag = "";
    if (r) return e;
    fx = ia; fy = ib;
    if (sel == 3'b001) fx = ~ia;
    if (sel == 3'b010) fy = ~ib;
    case (sel)
      3'b001, 3'b010, 3'b011: begin
        ux = int'(fx); uy = int'(fy);
        t  = ux + uy + int'(c);
        e.z  = t[3:0];
        e.co = (t >= 16);
        sx = (ux >= 8) ? ux - 16 : ux;
        sy = (uy >= 8) ? uy - 16 : uy;
        st = sx + sy + int'(c);
        e.ov = (st > 7) || (st < -8);
      end
      3'b100: e.z = ia ^ ib;
      3'b101: e.z = ia | ib;
      3'b110: e.z = ia & ib;
      3'b111: e.z = 4'hF;
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic r, input logic [2:0] sel, input logic [3:0] ia,
                       input logic [3:0] ib, input logic c, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst = r; {s2, s1, s0} = sel; a = ia; b = ib; ci = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_chk++;
    if (z !== got.z) begin
      n_fail++;
      $display("FAIL %s z: got %h want %h", got.tag, z, got.z);
    end
    n_chk++;
    if (co !== got.co) begin
      n_fail++;
      $display("FAIL %s co: got %b want %b", got.tag, co, got.co);
    end
`ifdef ALU_OVF_EN
    n_chk++;
    if (ov !== got.ov) begin
      n_fail++;
      $display("FAIL %s ov: got %b want %b", got.tag, ov, got.ov);
    end
`endif
  endtask

  vec_t tbl[$];

  initial begin
    exp_t e;
    rst = 1'b1; {s2, s1, s0} = 3'b011; a = 4'hF; b = 4'hF; ci = 1'b0;

    //            rst sel     a     b     ci    z     co    ov
    tbl.push_back('{1'b1, 3'b011, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 3'b011, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 4'h3, 4'h5, 1'b1, 4'h2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 4'hC, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 4'hC, 4'hA, 1'b1, 4'hE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b110, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 4'hC, 4'hA, 1'b1, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b111, 4'hC, 4'hA, 1'b1, 4'hF, 1'b0, 1'b0});
    // Mid-operation reset, then overflow corners.
    tbl.push_back('{1'b0, 3'b011, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 3'b011, 4'h7, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 3'b100, 4'h8, 4'h1, 1'b1, 4'h9, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      e.z = tbl[i].z; e.co = tbl[i].co; e.ov = tbl[i].ov;
      e.tag = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].ci, e);
    end

    for (int i = 0; i < 16; i++) begin
      logic [3:0] ia, ib;
      ia = 4'(i % 4); ib = 4'(i / 4);
      e = model(1'b0, 3'b011, ia, ib, 1'b0);
      e.tag = $sformatf("sweep%0d", i);
      drive(1'b0, 3'b011, ia, ib, 1'b0, e);
    end

    for (int i = 0; i < 200; i++) begin
      logic       r, c;
      logic [2:0] sel;
      logic [3:0] ia, ib;
      r   = ($urandom_range(0, 15) == 0);
      sel = 3'($urandom_range(0, 7));
      ia  = 4'($urandom_range(0, 15));
      ib  = 4'($urandom_range(0, 15));
      c   = 1'($urandom_range(0, 1));
      e = model(r, sel, ia, ib, c);
      e.tag = $sformatf("rnd%0d_s%0d_%h_%h_%b", i, sel, ia, ib, c);
      drive(r, sel, ia, ib, c, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
